// File: rtl/sar_code_register_if.sv
// Signal bundle between the SAR control block and its analog front end / back end.
// The master drives the start request and comparator decision; the slave is the SAR register.
interface sar_code_register_if #(
    parameter int N = 10
);
    logic         i_start;
    logic         i_comp;
    logic         o_sample;
    logic [N-1:0] o_dac_code;
    logic [N-1:0] o_trial_bit;
    logic         o_busy;
    logic [N-1:0] o_data;
    logic         o_valid;

    modport master (
        output i_start,
        output i_comp,
        input  o_sample,
        input  o_dac_code,
        input  o_trial_bit,
        input  o_busy,
        input  o_data,
        input  o_valid
    );

    modport slave (
        input  i_start,
        input  i_comp,
        output o_sample,
        output o_dac_code,
        output o_trial_bit,
        output o_busy,
        output o_data,
        output o_valid
    );
endinterface

// File: rtl/sar_code_register.sv
// Successive-approximation register: samples for SAMPLE_CYCLES, then resolves one bit per
// clock from MSB to LSB using the comparator, and publishes the code with a one-cycle pulse.
module sar_code_register #(
    parameter int ADC_RESOLUTION = 10,
    parameter int SAMPLE_CYCLES  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    sar_code_register_if.slave   bus
);
    localparam int N  = ADC_RESOLUTION;
    localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [N-1:0]  MSB_ONEHOT  = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2
    } state_t;

    state_t          state_reg,  state_next;
    logic [CW-1:0]   count_reg,  count_next;
    logic [N-1:0]    dac_reg,    dac_next;
    logic [N-1:0]    trial_reg,  trial_next;
    logic [N-1:0]    data_reg,   data_next;
    logic            valid_reg,  valid_next;
    logic [N-1:0]    dac_step;

    // Per-bit trial update: the bit under test takes the comparator decision, the bit just
    // below it is raised as the next trial, every other bit keeps its value.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : gen_bit
            if (gi == N - 1) begin : gen_top
                assign dac_step[gi] = trial_reg[gi] ? bus.i_comp : dac_reg[gi];
            end else begin : gen_low
                assign dac_step[gi] = trial_reg[gi]     ? bus.i_comp :
                                      trial_reg[gi + 1] ? 1'b1       : dac_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            dac_reg   <= '0;
            trial_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            dac_reg   <= dac_next;
            trial_reg <= trial_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        dac_next   = dac_reg;
        trial_next = trial_reg;
        data_next  = data_reg;
        valid_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                dac_next   = '0;
                trial_next = '0;
                if (bus.i_start) begin
                    state_next = ST_SAMPLE;
                    count_next = '0;
                end
            end

            ST_SAMPLE: begin
                if (count_reg == SAMPLE_LAST) begin
                    state_next = ST_CONVERT;
                    count_next = '0;
                    dac_next   = MSB_ONEHOT;
                    trial_next = MSB_ONEHOT;
                end else begin
                    count_next = count_reg + CW'(1);
                end
            end

            ST_CONVERT: begin
                if (trial_reg[0]) begin
                    // LSB decided: the stepped code is the final result
                    data_next  = dac_step;
                    valid_next = 1'b1;
                    state_next = ST_IDLE;
                    dac_next   = '0;
                    trial_next = '0;
                end else begin
                    dac_next   = dac_step;
                    trial_next = trial_reg >> 1;
                end
            end

            default: begin
                state_next = ST_IDLE;
                count_next = '0;
                dac_next   = '0;
                trial_next = '0;
            end
        endcase
    end

    assign bus.o_sample    = (state_reg == ST_SAMPLE);
    assign bus.o_busy      = (state_reg == ST_SAMPLE) || (state_reg == ST_CONVERT);
    assign bus.o_dac_code  = dac_reg;
    assign bus.o_trial_bit = trial_reg;
    assign bus.o_data      = data_reg;
    assign bus.o_valid     = valid_reg;

    // The trial pointer must stay one-hot for the whole conversion
    always_ff @(posedge i_clk) begin
        if (!i_rst && state_reg == ST_CONVERT) begin
            assert ($onehot(trial_reg));
        end
    end
endmodule

// File: tb/tb_sar_code_register.sv
// Randomized scoreboard bench for sar_code_register: a binary-search reference model predicts
// every trial code, the final result and its cycle; a negedge monitor pops and compares.
module tb_sar_code_register;
    localparam int N  = 10;
    localparam int S  = 2;
    localparam int N2 = 4;
    localparam int S2 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    int   cur_vin  = 0;
    int   cur_mode = 0;    // 0: behavioural comparator, 1: tied high, 2: tied low
    int   vin2     = 9;
    int   last_data = 0;
    int   sample_run = 0;
    int   v2_seen = 0;

    int   exp_dac_q[$];
    int   exp_trial_q[$];
    int   exp_data_q[$];
    int   exp_cyc_q[$];
    int   exp2_dac_q[$];
    int   exp2_cyc_q[$];

    sar_code_register_if #(.N(N))  bus ();
    sar_code_register_if #(.N(N2)) bus2 ();

    sar_code_register #(.ADC_RESOLUTION(N), .SAMPLE_CYCLES(S)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    sar_code_register #(.ADC_RESOLUTION(N2), .SAMPLE_CYCLES(S2)) dut2 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit accept(input int mode, input int vin, input int trial);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        return (vin >= trial);
    endfunction

    // Reference: plain binary search over the code space, MSB first
    function automatic void push_conv(input int vin, input int mode, input int start_edge);
        int code;
        int trial;
        code = 0;
        for (int b = N - 1; b >= 0; b--) begin
            trial = code | (1 << b);
            exp_dac_q.push_back(trial);
            exp_trial_q.push_back(1 << b);
            if (accept(mode, vin, trial)) code = trial;
        end
        exp_data_q.push_back(code);
        exp_cyc_q.push_back(start_edge + S + N);
    endfunction

    // Comparator model: responds to the DAC code shortly after each edge
    initial begin
        bus.i_comp  = 1'b0;
        bus2.i_comp = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.i_comp  = accept(cur_mode, cur_vin, int'(bus.o_dac_code));
            bus2.i_comp = (vin2 >= int'(bus2.o_dac_code));
        end
    end

    // Monitor for the default instance
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (rst) begin
                sample_run = 0;
                last_data  = 0;
                exp_dac_q.delete();
                exp_trial_q.delete();
                exp_data_q.delete();
                exp_cyc_q.delete();
            end else begin
                if (bus.o_sample) begin
                    sample_run++;
                    chk("sample_dac", int'(bus.o_dac_code), 0);
                    chk("sample_busy", int'(bus.o_busy), 1);
                end
                if (bus.o_busy && !bus.o_sample) begin
                    if (exp_dac_q.size() == 0) begin
                        chk("unexpected_convert", int'(bus.o_busy), 0);
                    end else begin
                        chk("dac_code", int'(bus.o_dac_code), exp_dac_q.pop_front());
                        chk("trial_bit", int'(bus.o_trial_bit), exp_trial_q.pop_front());
                        if (bus.o_trial_bit == N'(1 << (N - 1))) begin
                            chk("sample_len", sample_run, S);
                            sample_run = 0;
                        end
                    end
                end
                if (!bus.o_busy) begin
                    chk("idle_dac", int'(bus.o_dac_code), 0);
                    chk("idle_trial", int'(bus.o_trial_bit), 0);
                    chk("idle_sample", int'(bus.o_sample), 0);
                end
                if (bus.o_valid) begin
                    if (exp_data_q.size() == 0) begin
                        chk("unexpected_valid", int'(bus.o_valid), 0);
                    end else begin
                        d = exp_data_q.pop_front();
                        chk("data", int'(bus.o_data), d);
                        chk("valid_cycle", cyc, exp_cyc_q.pop_front());
                        last_data = d;
                    end
                end else begin
                    chk("data_hold", int'(bus.o_data), last_data);
                end
            end
        end
    end

    // Monitor for the small-parameter instance
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus2.o_busy && !bus2.o_sample && exp2_dac_q.size() > 0)
                    chk("v2_dac_code", int'(bus2.o_dac_code), exp2_dac_q.pop_front());
                if (bus2.o_valid) begin
                    v2_seen++;
                    chk("v2_data", int'(bus2.o_data), vin2);
                    if (exp2_cyc_q.size() > 0)
                        chk("v2_valid_cycle", cyc, exp2_cyc_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic run_conv(input int vin, input int mode);
        @(posedge clk);
        #1;
        cur_vin  = vin;
        cur_mode = mode;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        push_conv(vin, mode, cyc);
        repeat (S + N) @(posedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_sample"}, int'(bus.o_sample), 0);
        chk({tag, "_busy"},   int'(bus.o_busy), 0);
        chk({tag, "_dac"},    int'(bus.o_dac_code), 0);
        chk({tag, "_trial"},  int'(bus.o_trial_bit), 0);
        chk({tag, "_data"},   int'(bus.o_data), 0);
        chk({tag, "_valid"},  int'(bus.o_valid), 0);
    endtask

    initial begin
        logic [3:0] seq2 [4];
        int e;
        int vin;
        int mode;
        bit found;

        seq2 = '{4'h8, 4'hC, 4'hA, 4'h9};
        bus.i_start  = 1'b0;
        bus2.i_start = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Small-parameter instance: 4 bits, 1 sample cycle, VIN=9
        @(posedge clk);
        #1;
        bus2.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus2.i_start = 1'b0;
        for (int i = 0; i < 4; i++) exp2_dac_q.push_back(int'(seq2[i]));
        exp2_cyc_q.push_back(cyc + S2 + N2);
        repeat (S2 + N2 + 2) @(posedge clk);

        // Directed VIN=0x2AB, then comparator tied high and tied low
        run_conv(683, 0);
        run_conv(int'($urandom_range(0, 1023)), 1);
        run_conv(int'($urandom_range(0, 1023)), 2);

        // Randomized conversions with random idle gaps
        for (int i = 0; i < 6; i++) begin
            vin  = int'($urandom_range(0, 1023));
            mode = int'($urandom_range(0, 4));
            if (mode > 2) mode = 0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_conv(vin, mode);
        end

        // i_start held high: accepted every S+N+1 edges
        @(posedge clk);
        #1;
        cur_vin  = int'($urandom_range(0, 1023));
        cur_mode = 0;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        e = cyc;
        for (int j = 0; j < 3; j++) push_conv(cur_vin, 0, e + j * (S + N + 1));
        repeat (2 * (S + N + 1)) @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        repeat (S + N + 2) @(posedge clk);

        // Single start pulse during CONVERT must be ignored
        @(posedge clk);
        #1;
        cur_vin = int'($urandom_range(0, 1023));
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        push_conv(cur_vin, 0, cyc);
        repeat (S + 3) @(posedge clk);
        #1;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        repeat (N + 3) @(posedge clk);

        // Back-to-back: second start only in the valid cycle of the first
        @(posedge clk);
        #1;
        cur_vin = 683;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        push_conv(683, 0, cyc);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.o_valid) found = 1'b1;
        end
        chk("b2b_first_valid_seen", int'(found), 1);
        cur_vin = 341;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        push_conv(341, 0, cyc);
        repeat (S + N + 2) @(posedge clk);

        // Asynchronous reset in the middle of CONVERT
        @(posedge clk);
        #1;
        cur_vin = int'($urandom_range(0, 1023));
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        push_conv(cur_vin, 0, cyc);
        repeat (S + 4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (S + N + 4) @(posedge clk);

        // Fresh conversion after reset release
        run_conv(int'($urandom_range(0, 1023)), 0);
        repeat (4) @(posedge clk);

        chk("pending_results", exp_data_q.size(), 0);
        chk("pending_trials", exp_dac_q.size(), 0);
        chk("v2_pending", exp2_dac_q.size() + exp2_cyc_q.size(), 0);
        chk("v2_valid_count", v2_seen, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
